pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases: load-use hazards, EX-stage control redirects (taken branch/jal/jalr), and multi-cycle data-memory accesses. Memory accesses use a ready handshake with a timeout watchdog. The block also keeps saturating performance counters.

Parameters:
WAIT_LIMIT, 8, max stall cycles per data-memory access before forced release (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX (ID/EX output)
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolves taken branch/jal/jalr
mem_read  in  1  EX/MEM mem_read output
mem_write  in  1  EX/MEM mem_write output
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID capture enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX capture enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_en  out  1  EX/MEM capture enable
mem_wb_en  out  1  MEM/WB capture enable
dmem_req  out  1  data memory request
mem_error  out  1  sticky watchdog-timeout flag
stall_cycles  out  CNT_W  count of cycles with pc_en=0
flush_events  out  CNT_W  count of redirect flushes

Behaviour:
- Reset state: state=RUN, wait_cnt=0, mem_error=0, both counters=0.
- While reset is low, all enables=0, flushes=0 and dmem_req=0.
- Register outputs: state, wait_cnt, mem_error, counters. All other outputs are combinational from state, wait_cnt and inputs, with zero latency.
- mem_access = mem_read | mem_write. dmem_req = mem_access (out of reset).
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- timeout = (state==MEM_WAIT) & (wait_cnt==WAIT_LIMIT).
- mem_stall = mem_access & ~dmem_ready & ~timeout.
- Priority order: mem_stall > ex_redirect > load_use > normal.
  - mem_stall: all enables 0, flushes 0. The whole pipe holds; MEM/WB does not capture.
  - ex_redirect: all enables 1, if_id_flush=1, id_ex_flush=1. The PC loads the target.
  - load_use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 (bubble), ex_mem_en=1, mem_wb_en=1.
  - normal: all enables 1, flushes 0.
- The redirect beats load-use because the ID instruction is squashed anyway. A redirect arriving during a mem stall is held in the frozen EX stage and applied on the release cycle.
- FSM:
  - RUN: if mem_access & ~dmem_ready, go to MEM_WAIT with wait_cnt<=1; otherwise stay.
  - MEM_WAIT, dmem_ready=1: go to RUN, wait_cnt<=0.
  - MEM_WAIT, timeout (ready still low): go to RUN, wait_cnt<=0, mem_error<=1. The cycle is treated as a completed access: enables follow the next priority rule.
  - MEM_WAIT, otherwise: wait_cnt<=wait_cnt+1.
- An unanswered access therefore stalls exactly WAIT_LIMIT cycles, then releases on cycle WAIT_LIMIT+1.
- A back-to-back access following a release re-enters via RUN normally.
- mem_error is sticky until reset.
- stall_cycles increments each cycle pc_en=0 (out of reset). flush_events increments each cycle the ex_redirect rule is applied. Both saturate at all-ones.
- wait_cnt width = clog2(WAIT_LIMIT+1).
- Reset asserted mid-wait returns to RUN immediately (async) and clears the counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Redirect: ex_redirect=1 one cycle, with load_use also true -> if_id_flush=id_ex_flush=1, pc_en=1, flush_events=1, stall_cycles unchanged.
- Memory wait: mem_read=1, dmem_ready low 3 cycles then high -> all enables 0 for 3 cycles, all 1 on the 4th, state back to RUN, stall_cycles=3, mem_error=0.
- Timeout: WAIT_LIMIT=4, mem_write=1, dmem_ready=0 forever -> 4 stall cycles, release on 5th with mem_error=1 held; the next access stalls again.
- Redirect during mem stall: ex_redirect=1 held while dmem_ready=0 for 2 cycles -> no flush during the stall; flush on the release cycle; flush_events=1.
- Saturation/reset: CNT_W=4, 20 stall cycles -> stall_cycles=15; drop reset mid-MEM_WAIT -> all outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and pipe_hazard_ctrl.
// The master side is the datapath; the slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_read;
  logic             mem_write;
  logic             dmem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             dmem_req;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_read, mem_write, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, dmem_req, mem_error, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_read, mem_write, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, dmem_req, mem_error, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, EX redirect and
// multi-cycle data-memory stalls with a timeout watchdog and saturating counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_LIMIT = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WCNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(WAIT_LIMIT);
  localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WAIT_ZERO = {WCNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;

  logic mem_access;
  logic load_use;
  logic timeout;
  logic mem_stall;
  logic redirect_apply;

  logic pc_en_raw, if_id_en_raw, if_id_flush_raw, id_ex_en_raw;
  logic id_ex_flush_raw, ex_mem_en_raw, mem_wb_en_raw;

  assign mem_access = hz.mem_read | hz.mem_write;
  assign load_use   = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
  assign timeout    = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_MAX);
  assign mem_stall  = mem_access & ~hz.dmem_ready & ~timeout;
  // A redirect seen during a memory stall is held in frozen EX and fires on release.
  assign redirect_apply = ~mem_stall & hz.ex_redirect;

  // FSM state, watchdog count and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= WAIT_ZERO;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state logic for the memory-wait FSM
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (mem_access && !hz.dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          state_d    = RUN;
          wait_cnt_d = WAIT_ZERO;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = WAIT_ZERO;
        end else if (timeout) begin
          state_d     = RUN;
          wait_cnt_d  = WAIT_ZERO;
          mem_error_d = 1'b1;
        end else begin
          state_d    = MEM_WAIT;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase
  end

  // Stage enable/flush decode, highest priority first
  always_comb begin
    pc_en_raw       = 1'b1;
    if_id_en_raw    = 1'b1;
    if_id_flush_raw = 1'b0;
    id_ex_en_raw    = 1'b1;
    id_ex_flush_raw = 1'b0;
    ex_mem_en_raw   = 1'b1;
    mem_wb_en_raw   = 1'b1;
    if (mem_stall) begin
      pc_en_raw     = 1'b0;
      if_id_en_raw  = 1'b0;
      id_ex_en_raw  = 1'b0;
      ex_mem_en_raw = 1'b0;
      mem_wb_en_raw = 1'b0;
    end else if (hz.ex_redirect) begin
      if_id_flush_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
    end else if (load_use) begin
      pc_en_raw       = 1'b0;
      if_id_en_raw    = 1'b0;
      id_ex_flush_raw = 1'b1;
    end else begin
      pc_en_raw = 1'b1;
    end
  end

  // Saturating performance counter next values
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en_raw && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (redirect_apply && (flush_events_q != CNT_MAX)) begin
      flush_events_d = flush_events_q + CNT_ONE;
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= CNT_ZERO;
      flush_events_q <= CNT_ZERO;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  // Combinational controls are forced idle while reset is held low.
  assign hz.pc_en        = reset & pc_en_raw;
  assign hz.if_id_en     = reset & if_id_en_raw;
  assign hz.if_id_flush  = reset & if_id_flush_raw;
  assign hz.id_ex_en     = reset & id_ex_en_raw;
  assign hz.id_ex_flush  = reset & id_ex_flush_raw;
  assign hz.ex_mem_en    = reset & ex_mem_en_raw;
  assign hz.mem_wb_en    = reset & mem_wb_en_raw;
  assign hz.dmem_req     = reset & mem_access;
  assign hz.mem_error    = mem_error_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_LIMIT=4, CNT_W=4): a vector table
// plus hand sequences for counter saturation and reset during a memory wait.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipe_hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, dmem_req}
  localparam logic [7:0] C_RST   = 8'b0000_0000;
  localparam logic [7:0] C_NORM  = 8'b1101_0110;
  localparam logic [7:0] C_NORMQ = 8'b1101_0111;
  localparam logic [7:0] C_LU    = 8'b0001_1110;
  localparam logic [7:0] C_LUQ   = 8'b0001_1111;
  localparam logic [7:0] C_RD    = 8'b1111_1110;
  localparam logic [7:0] C_RDQ   = 8'b1111_1111;
  localparam logic [7:0] C_STALL = 8'b0000_0001;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       exmr;
    logic       redir;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [7:0] ctl;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] exrd,
                     input logic exmr, input logic redir, input logic mr,
                     input logic mw, input logic rdy, input logic [7:0] ctl,
                     input logic [3:0] stall, input logic [3:0] flush, input logic err);
    vec_t v;
    v.rst = rst;  v.rs1 = rs1;  v.rs2 = rs2;  v.u1 = u1;  v.u2 = u2;
    v.exrd = exrd;  v.exmr = exmr;  v.redir = redir;  v.mr = mr;  v.mw = mw;
    v.rdy = rdy;  v.ctl = ctl;  v.stall = stall;  v.flush = flush;  v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    hz.id_rs1      = v.rs1;
    hz.id_rs2      = v.rs2;
    hz.id_uses_rs1 = v.u1;
    hz.id_uses_rs2 = v.u2;
    hz.ex_rd       = v.exrd;
    hz.ex_mem_read = v.exmr;
    hz.ex_redirect = v.redir;
    hz.mem_read    = v.mr;
    hz.mem_write   = v.mw;
    hz.dmem_ready  = v.rdy;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] exrd,
                        input logic exmr, input logic mr, input logic mw, input logic rdy);
    hz.id_rs1      = rs1;
    hz.id_rs2      = 5'd0;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = 1'b0;
    hz.ex_rd       = exrd;
    hz.ex_mem_read = exmr;
    hz.ex_redirect = 1'b0;
    hz.mem_read    = mr;
    hz.mem_write   = mw;
    hz.dmem_ready  = rdy;
  endtask

  function automatic logic [7:0] ctl_now();
    return {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
            hz.ex_mem_en, hz.mem_wb_en, hz.dmem_req};
  endfunction

  function automatic logic [8:0] regs_now();
    return {hz.mem_error, hz.stall_cycles, hz.flush_events};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    hz.ex_redirect = 1'b0;

    //   rst  rs1    rs2    u1    u2    exrd   exmr  redir mr    mw    rdy   ctl      st     fl     err
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_RST,   4'd0,  4'd0, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd0,  4'd0, 1'b0);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,    4'd1,  4'd0, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd1,  4'd0, 1'b0);
    add(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,    4'd2,  4'd0, 1'b0);
    add(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd2,  4'd0, 1'b0);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd2,  4'd0, 1'b0);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RD,    4'd2,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, 4'd3,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, 4'd4,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, 4'd5,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NORMQ, 4'd5,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd5,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL, 4'd6,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL, 4'd7,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL, 4'd8,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL, 4'd9,  4'd1, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NORMQ, 4'd9,  4'd1, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL, 4'd10, 4'd1, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORMQ, 4'd10, 4'd1, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_STALL, 4'd11, 4'd1, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_STALL, 4'd12, 4'd1, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C_RDQ,   4'd12, 4'd2, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd12, 4'd2, 1'b1);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, 4'd13, 4'd2, 1'b1);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_LUQ,   4'd14, 4'd2, 1'b1);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM,  4'd14, 4'd2, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d ctl", i), {8'd0, ctl_now()}, {8'd0, vecs[i].ctl});
      @(posedge clk);
      #1;
      check($sformatf("v%0d regs", i), {7'd0, regs_now()},
            {7'd0, vecs[i].err, vecs[i].stall, vecs[i].flush});
    end

    // Saturation: reset, then 20 consecutive load-use stall cycles.
    @(negedge clk);
    reset = 1'b0;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    set_in(5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("sat ctl", {8'd0, ctl_now()}, {8'd0, C_LU});
    repeat (20) @(posedge clk);
    #1;
    check("sat regs", {7'd0, regs_now()}, {7'd0, 1'b0, 4'd15, 4'd0});

    // Reset dropped in the middle of a memory wait.
    @(negedge clk);
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst ctl", {8'd0, ctl_now()}, {8'd0, C_RST});
    check("rst regs", {7'd0, regs_now()}, 16'd0);

    // Fresh access after reset: exactly four stall cycles, release on the fifth.
    @(negedge clk);
    reset = 1'b1;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("post-rst stall%0d", k), {8'd0, ctl_now()}, {8'd0, C_STALL});
      @(negedge clk);
    end
    #2;
    check("post-rst release", {8'd0, ctl_now()}, {8'd0, C_NORMQ});
    @(posedge clk);
    #1;
    check("post-rst regs", {7'd0, regs_now()}, {7'd0, 1'b1, 4'd4, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
